// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/decode/execute control FSM (optional ILLEGAL_TRAP_EN)
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int ALUW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     ir,
  input  logic            stop,
  input  logic            mem_ready,
  output logic            gra,
  output logic            grb,
  output logic            grc,
  output logic            r_in,
  output logic            r_out,
  output logic            ba_out,
  output logic            pc_out,
  output logic            pc_in,
  output logic            inc_pc,
  output logic            mar_in,
  output logic            mdr_in,
  output logic            mdr_out,
  output logic            ir_in,
  output logic            y_in,
  output logic            z_in,
  output logic            zlo_out,
  output logic            c_out,
  output logic            mem_read,
  output logic            mem_write,
  output logic [ALUW-1:0] alu_op,
  output logic            run,
  output logic            illegal
);

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_LD, C_LDI, C_ST, C_ALUR, C_ALUI, C_NOP, C_HALT, C_ILL
  } cls_t;

  state_t         state_q, state_d;
  cls_t           cls_q;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] opcode;
  logic           unused_ir;

  assign opcode    = ir[31 -: OPW];
  assign unused_ir = ^ir[31-OPW:0];

  function automatic cls_t decode(input logic [OPW-1:0] o);
    if (o == OPW'(0))                         return C_LD;
    else if (o == OPW'(1))                    return C_LDI;
    else if (o == OPW'(2))                    return C_ST;
    else if (o >= OPW'(3) && o <= OPW'(10))   return C_ALUR;
    else if (o == OPW'(11) || o == OPW'(12))  return C_ALUI;
    else if (o == OPW'(26))                   return C_NOP;
    else if (o == OPW'(27))                   return C_HALT;
    else                                      return C_ILL;
  endfunction

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // State register; opcode and its class are latched as the IR is loaded (T2 -> T3)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_T0;
      cls_q   <= C_NOP;
      op_q    <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == S_T2) begin
        cls_q <= decode(opcode);
        op_q  <= opcode;
      end
`ifdef ILLEGAL_TRAP_EN
      if (state_q == S_T3 && cls_q == C_ILL) illegal_q <= 1'b1;
`endif
    end
  end

  assign run = (state_q != S_HALT);

  // ALU follows the opcode only while an ALU-class instruction executes
  always_comb begin
    alu_op = ALUW'(5'b00011);
    if ((cls_q == C_ALUR || cls_q == C_ALUI) &&
        (state_q == S_T3 || state_q == S_T4 || state_q == S_T5))
      alu_op = ALUW'(op_q);
  end

  // Next-state and strobe decode; mem states hold until mem_ready
  always_comb begin
    state_d = state_q;
    gra = 1'b0; grb = 1'b0; grc = 1'b0;
    r_in = 1'b0; r_out = 1'b0; ba_out = 1'b0;
    pc_out = 1'b0; pc_in = 1'b0; inc_pc = 1'b0;
    mar_in = 1'b0; mdr_in = 1'b0; mdr_out = 1'b0; ir_in = 1'b0;
    y_in = 1'b0; z_in = 1'b0; zlo_out = 1'b0; c_out = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    case (state_q)
      S_T0: begin
        if (stop) begin
          state_d = S_HALT;
        end else begin
          state_d = S_T1;
          // strobes suppressed while reset is held so nothing fires from the reset state
          if (rst_n) begin
            pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
          end
        end
      end
      S_T1: begin
        zlo_out = 1'b1; pc_in = 1'b1; mem_read = 1'b1; mdr_in = 1'b1;
        if (mem_ready) state_d = S_T2;
      end
      S_T2: begin
        mdr_out = 1'b1; ir_in = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        case (cls_q)
          C_ALUR, C_ALUI: begin
            grb = 1'b1; r_out = 1'b1; y_in = 1'b1; state_d = S_T4;
          end
          C_LDI, C_LD, C_ST: begin
            grb = 1'b1; ba_out = 1'b1; y_in = 1'b1; state_d = S_T4;
          end
          C_HALT: state_d = S_HALT;
`ifdef ILLEGAL_TRAP_EN
          C_ILL:  state_d = S_HALT;
`endif
          default: state_d = S_T0;
        endcase
      end
      S_T4: begin
        z_in = 1'b1;
        if (cls_q == C_ALUR) begin
          grc = 1'b1; r_out = 1'b1;
        end else begin
          c_out = 1'b1;
        end
        state_d = S_T5;
      end
      S_T5: begin
        zlo_out = 1'b1;
        if (cls_q == C_LD || cls_q == C_ST) begin
          mar_in = 1'b1; state_d = S_T6;
        end else begin
          gra = 1'b1; r_in = 1'b1; state_d = S_T0;
        end
      end
      S_T6: begin
        mdr_in = 1'b1;
        if (cls_q == C_ST) begin
          gra = 1'b1; r_out = 1'b1; state_d = S_T7;
        end else begin
          mem_read = 1'b1;
          if (mem_ready) state_d = S_T7;
        end
      end
      S_T7: begin
        if (cls_q == C_ST) begin
          mem_write = 1'b1;
          if (mem_ready) state_d = S_T0;
        end else begin
          mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; state_d = S_T0;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_T0;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - table-driven scoreboard bench for control_sequencer
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, stop, mem_ready;
  logic [31:0] ir;
  logic gra, grb, grc, r_in, r_out, ba_out, pc_out, pc_in, inc_pc;
  logic mar_in, mdr_in, mdr_out, ir_in, y_in, z_in, zlo_out, c_out;
  logic mem_read, mem_write, run, illegal;
  logic [4:0] alu_op;

  control_sequencer #(.OPW(5), .ALUW(5)) dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .stop(stop), .mem_ready(mem_ready),
    .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
    .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
    .zlo_out(zlo_out), .c_out(c_out), .mem_read(mem_read), .mem_write(mem_write),
    .alu_op(alu_op), .run(run), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [18:0] GRA  = 19'h40000, GRB  = 19'h20000, GRC  = 19'h10000;
  localparam logic [18:0] RIN  = 19'h08000, ROUT = 19'h04000, BAO  = 19'h02000;
  localparam logic [18:0] PCO  = 19'h01000, PCI  = 19'h00800, INC  = 19'h00400;
  localparam logic [18:0] MARI = 19'h00200, MDRI = 19'h00100, MDRO = 19'h00080;
  localparam logic [18:0] IRI  = 19'h00040, YI   = 19'h00020, ZI   = 19'h00010;
  localparam logic [18:0] ZLO  = 19'h00008, CO   = 19'h00004, MRD  = 19'h00002;
  localparam logic [18:0] MWR  = 19'h00001;
  localparam logic [4:0]  ADD  = 5'b00011;

  typedef struct {
    logic [31:0]       ir;
    int                n;
    int                stall_at;
    int                stall_n;
    logic [7:0][25:0]  tr;
  } vec_t;

  vec_t        vecs [10];
  logic [25:0] sb [$];
  int          compared = 0;
  int          mismatched = 0;

  function automatic logic [25:0] w(input logic [18:0] s, input logic [4:0] a);
    return {1'b1, 1'b0, a, s};
  endfunction

  function automatic logic [25:0] halt_w(input logic ill);
    return {1'b0, ill, ADD, 19'h0};
  endfunction

  function automatic logic [25:0] dut_word();
    return {run, illegal, alu_op, gra, grb, grc, r_in, r_out, ba_out, pc_out, pc_in,
            inc_pc, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in, zlo_out, c_out,
            mem_read, mem_write};
  endfunction

  logic [25:0] F0, F1, F2, IDLE;

  task automatic setv(input int i, input logic [31:0] irv, input int n, input int sa,
                      input int sn, input logic [25:0] t3, input logic [25:0] t4,
                      input logic [25:0] t5, input logic [25:0] t6, input logic [25:0] t7);
    vecs[i].ir = irv; vecs[i].n = n; vecs[i].stall_at = sa; vecs[i].stall_n = sn;
    vecs[i].tr[0] = F0; vecs[i].tr[1] = F1; vecs[i].tr[2] = F2;
    vecs[i].tr[3] = t3; vecs[i].tr[4] = t4; vecs[i].tr[5] = t5;
    vecs[i].tr[6] = t6; vecs[i].tr[7] = t7;
  endtask

  task automatic compare(input string name);
    logic [25:0] exp_w, got;
    exp_w = sb.pop_front();
    got   = dut_word();
    compared++;
    if (got !== exp_w) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, exp_w);
    end
  endtask

  // drive one cycle of inputs, sample at the falling edge, land just after the next rise
  task automatic cyc(input logic mr, input logic sp, input logic [25:0] e, input string name);
    mem_ready = mr;
    stop      = sp;
    sb.push_back(e);
    @(negedge clk);
    compare(name);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_now(input logic [25:0] e, input string name);
    sb.push_back(e);
    #1;
    compare(name);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stop  = 1'b0;
    chk_now(w(19'h0, ADD), "reset_asserted");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    F0   = w(PCO | MARI | INC | ZI, ADD);
    F1   = w(ZLO | PCI | MRD | MDRI, ADD);
    F2   = w(MDRO | IRI, ADD);
    IDLE = w(19'h0, ADD);
    setv(0, 32'h19918000, 6, -1, 0, w(GRB|ROUT|YI, 5'b00011), w(GRC|ROUT|ZI, 5'b00011),
         w(ZLO|GRA|RIN, 5'b00011), IDLE, IDLE);
    setv(1, 32'h50000000, 6, -1, 0, w(GRB|ROUT|YI, 5'b01010), w(GRC|ROUT|ZI, 5'b01010),
         w(ZLO|GRA|RIN, 5'b01010), IDLE, IDLE);
    setv(2, 32'h58000000, 6, -1, 0, w(GRB|ROUT|YI, 5'b01011), w(CO|ZI, 5'b01011),
         w(ZLO|GRA|RIN, 5'b01011), IDLE, IDLE);
    setv(3, 32'h60000000, 6, 1, 2, w(GRB|ROUT|YI, 5'b01100), w(CO|ZI, 5'b01100),
         w(ZLO|GRA|RIN, 5'b01100), IDLE, IDLE);
    setv(4, 32'h08000000, 6, -1, 0, w(GRB|BAO|YI, ADD), w(CO|ZI, ADD),
         w(ZLO|GRA|RIN, ADD), IDLE, IDLE);
    setv(5, 32'h00000000, 8, 6, 3, w(GRB|BAO|YI, ADD), w(CO|ZI, ADD),
         w(ZLO|MARI, ADD), w(MRD|MDRI, ADD), w(MDRO|GRA|RIN, ADD));
    setv(6, 32'h10000000, 8, -1, 0, w(GRB|BAO|YI, ADD), w(CO|ZI, ADD),
         w(ZLO|MARI, ADD), w(GRA|ROUT|MDRI, ADD), w(MWR, ADD));
    setv(7, 32'h10000000, 8, 7, 2, w(GRB|BAO|YI, ADD), w(CO|ZI, ADD),
         w(ZLO|MARI, ADD), w(GRA|ROUT|MDRI, ADD), w(MWR, ADD));
    setv(8, 32'hD0000000, 4, -1, 0, IDLE, IDLE, IDLE, IDLE, IDLE);
    setv(9, 32'hD0000000, 4, 1, 1, IDLE, IDLE, IDLE, IDLE, IDLE);

    rst_n = 1'b0; stop = 1'b0; mem_ready = 1'b1; ir = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_now(IDLE, "reset_state");
    rst_n = 1'b1;

    // table: every instruction class, with and without memory stalls
    for (int v = 0; v < 10; v++) begin
      ir = vecs[v].ir;
      for (int k = 0; k < vecs[v].n; k++) begin
        if (k == vecs[v].stall_at)
          for (int s = 0; s < vecs[v].stall_n; s++)
            cyc(1'b0, 1'b0, vecs[v].tr[k], $sformatf("v%0d_stall_c%0d", v, k));
        cyc(1'b1, 1'b0, vecs[v].tr[k], $sformatf("v%0d_c%0d", v, k));
      end
    end
    cyc(1'b1, 1'b0, F0, "final_t0");

    // reset while stalled in T1
    cyc(1'b0, 1'b0, F1, "t1_stall_a");
    cyc(1'b0, 1'b0, F1, "t1_stall_b");
    rst_n = 1'b0;
    chk_now(IDLE, "reset_mid_stall");
    @(posedge clk);
    #1;
    chk_now(IDLE, "reset_mid_stall_held");
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, F0, "after_reset_t0");

    // stop raised mid ALU_R: instruction finishes, T0 is silent, then HALT
    ir = 32'h19918000;
    cyc(1'b1, 1'b0, F1, "stop_t1");
    cyc(1'b1, 1'b0, F2, "stop_t2");
    cyc(1'b1, 1'b0, w(GRB|ROUT|YI, ADD), "stop_t3");
    cyc(1'b1, 1'b1, w(GRC|ROUT|ZI, ADD), "stop_t4");
    cyc(1'b1, 1'b1, w(ZLO|GRA|RIN, ADD), "stop_t5");
    cyc(1'b1, 1'b1, IDLE, "stop_t0_silent");
    cyc(1'b0, 1'b1, halt_w(1'b0), "stop_halt_a");
    cyc(1'b1, 1'b0, halt_w(1'b0), "stop_halt_b");
    do_reset();

    // illegal opcode 11111
    ir = 32'hF8000000;
    cyc(1'b1, 1'b0, F0, "ill_t0");
    cyc(1'b1, 1'b0, F1, "ill_t1");
    cyc(1'b1, 1'b0, F2, "ill_t2");
    cyc(1'b1, 1'b0, IDLE, "ill_t3");
`ifdef ILLEGAL_TRAP_EN
    cyc(1'b1, 1'b0, halt_w(1'b1), "ill_halt_a");
    cyc(1'b1, 1'b0, halt_w(1'b1), "ill_halt_sticky");
    do_reset();
`else
    cyc(1'b1, 1'b0, F0, "ill_as_nop_next_t0");
    cyc(1'b1, 1'b0, F1, "ill_as_nop_next_t1");
    do_reset();
`endif

    // HALT opcode parks the CPU; mem_ready activity has no effect
    ir = 32'hD8000000;
    cyc(1'b1, 1'b0, F0, "halt_t0");
    cyc(1'b1, 1'b0, F1, "halt_t1");
    cyc(1'b1, 1'b0, F2, "halt_t2");
    cyc(1'b1, 1'b0, IDLE, "halt_t3");
    cyc(1'b0, 1'b0, halt_w(1'b0), "halt_a");
    cyc(1'b1, 1'b0, halt_w(1'b0), "halt_b");
    do_reset();
    cyc(1'b1, 1'b0, F0, "final_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
